// File: rtl/udp_rx.sv
// Receive-side UDP layer: parses the 8-byte header, filters on protocol and
// destination port, and streams the payload with one cycle of latency.
module udp_rx #(
  parameter logic [15:0] P_LOCAL_UDP_PORT = 16'h8080,
  parameter bit          P_PORT_FILTER_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_local_udp_port,
  input  logic        i_local_udp_valid,
  input  logic [7:0]  i_ip_type,
  input  logic [7:0]  i_ip_data,
  input  logic        i_ip_valid,
  input  logic        i_ip_last,
  output logic [7:0]  o_udp_data,
  output logic [15:0] o_udp_len,
  output logic        o_udp_last,
  output logic        o_udp_valid,
  output logic [15:0] o_src_udp_port,
  output logic        o_udp_err
);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_DATA, S_DROP} state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [15:0] local_port_q;
  logic [15:0] src_q;
  logic [7:0]  dst_hi_q;
  logic [15:0] len_q;

  logic [15:0] cnt_d;
  logic [15:0] dst_d;
  logic [15:0] len_d;
  logic        port_miss_d;
  logic        final_byte_d;

  always_comb begin
    cnt_d        = i_ip_last ? 16'd0 : cnt_q + 16'd1;
    dst_d        = {dst_hi_q, i_ip_data};
    len_d        = {len_q[15:8], i_ip_data};
    port_miss_d  = P_PORT_FILTER_EN && (dst_d != local_port_q);
    final_byte_d = (cnt_q == len_q - 16'd1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 16'd0;
      local_port_q   <= P_LOCAL_UDP_PORT;
      src_q          <= 16'd0;
      dst_hi_q       <= 8'd0;
      len_q          <= 16'd0;
      o_udp_data     <= 8'd0;
      o_udp_len      <= 16'd0;
      o_udp_last     <= 1'b0;
      o_udp_valid    <= 1'b0;
      o_src_udp_port <= 16'd0;
      o_udp_err      <= 1'b0;
    end else begin
      o_udp_valid <= 1'b0;
      o_udp_last  <= 1'b0;
      o_udp_err   <= 1'b0;

      // The beat-3 compare reads the pre-load value, so a coinciding load
      // only affects later datagrams.
      if (i_local_udp_valid) local_port_q <= i_local_udp_port;

      if (i_ip_valid) begin
        cnt_q <= cnt_d;
        case (state_q)
          S_IDLE: begin
            src_q[15:8] <= i_ip_data;
            if (i_ip_last)              state_q <= S_IDLE;
            else if (i_ip_type == 8'd17) state_q <= S_HEAD;
            else                        state_q <= S_DROP;
          end
          S_HEAD: begin
            case (cnt_q[2:0])
              3'd1: src_q[7:0] <= i_ip_data;
              3'd2: dst_hi_q <= i_ip_data;
              3'd3: if (port_miss_d) state_q <= S_DROP;
              3'd4: len_q[15:8] <= i_ip_data;
              3'd5: begin
                len_q[7:0] <= i_ip_data;
                if (len_d <= 16'd8) state_q <= S_DROP;
              end
              3'd7: begin
                state_q        <= S_DATA;
                o_src_udp_port <= src_q;
                o_udp_len      <= len_q - 16'd8;
              end
              default: ;
            endcase
            // A header cut short by the IP layer is silently discarded.
            if (i_ip_last) state_q <= S_IDLE;
          end
          S_DATA: begin
            o_udp_valid <= 1'b1;
            o_udp_data  <= i_ip_data;
            if (final_byte_d) begin
              o_udp_last <= 1'b1;
              state_q    <= i_ip_last ? S_IDLE : S_DROP;
            end else if (i_ip_last) begin
              o_udp_last <= 1'b1;
              o_udp_err  <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
          S_DROP: begin
            if (i_ip_last) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/udp_rx.md
Name: udp_rx

Overview:
- Receive-side UDP layer. Consumes the IP-layer payload stream (one byte per beat) from the IP receiver.
- Parses the 8-byte UDP header: source port, destination port, length, checksum.
- Filters on protocol type 17 and the local destination port, strips the header and any trailing Ethernet padding, then forwards the payload to the user with its length and source port.
- No buffering: the port decision is known before the first payload byte arrives.

Parameters:
- P_LOCAL_UDP_PORT, 16'h8080, reset value of the local (accepted destination) UDP port.
- P_PORT_FILTER_EN, 1, 1 = drop datagrams whose destination port differs from the local port; 0 = accept any port.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_local_udp_port  in  16  new local port.
- i_local_udp_valid  in  1  load strobe for i_local_udp_port.
- i_ip_type  in  8  IP protocol of the current packet; sampled on the first beat.
- i_ip_data  in  8  IP payload byte.
- i_ip_valid  in  1  beat qualifier; gaps are allowed within a packet.
- i_ip_last  in  1  final beat of the IP payload; qualified by i_ip_valid.
- o_udp_data  out  8  payload byte.
- o_udp_len  out  16  payload length (UDP length - 8); stable from the first payload beat through last.
- o_udp_last  out  1  final payload beat.
- o_udp_valid  out  1  payload beat qualifier.
- o_src_udp_port  out  16  source port of the current/last accepted datagram.
- o_udp_err  out  1  one-cycle pulse with o_udp_last when a datagram is truncated.

Behaviour:
- Reset: all outputs 0; local port register = P_LOCAL_UDP_PORT; state = IDLE; byte counter = 0.
- Local port register:
  - Loads i_local_udp_port on i_local_udp_valid, any time.
  - Takes effect from the next datagram's port compare.
  - A load coinciding with the byte 3 compare: the compare uses the old value.
- Byte counter (16 bit):
  - Increments on each i_ip_valid beat and clears after the last beat.
  - Beat 0 is the first byte of the packet.
- State machine:
  - IDLE: on a valid beat 0 with i_ip_type == 17, go to HEAD; with i_ip_type != 17, go to DROP. If that beat also carries last, stay IDLE.
  - HEAD, beats 0-7 are captured:
    - src port = beats 0,1 (MSB first).
    - dst port = beats 2,3.
    - length = beats 4,5.
    - checksum = beats 6,7, ignored.
  - At beat 3: if the filter is enabled and dst != local port, go to DROP.
  - At beat 5: if length <= 8, go to DROP. The datagram carries no payload and produces no output.
  - At beat 7: go to DATA; o_src_udp_port and o_udp_len are updated.
  - i_ip_last during HEAD: return to IDLE with no output and no error.
  - DATA: each beat, with payload index k = beat - 8, is forwarded.
    - The beat with k = len-9 (final payload byte): o_udp_last = 1, then go to DROP to discard padding. If i_ip_last arrives on the same beat, go straight to IDLE.
    - i_ip_last with k < len-9 (truncation): forward that byte with o_udp_last = 1 and o_udp_err = 1, then go to IDLE.
  - DROP: consume beats until i_ip_last, then go to IDLE. No outputs are produced.
- Latency:
  - Outputs are registered, 1 cycle after the input beat.
  - o_udp_valid mirrors the input beat pattern, including gaps.
  - o_udp_last and o_udp_err are asserted only with o_udp_valid.
- A new packet may start on the cycle after i_ip_last, with no idle cycle required.
- Reset mid-packet: outputs drop to 0 immediately. The remainder of the interrupted packet is treated as a new packet from beat 0.

Test Plan:
- Type 17, src 0x1234, dst 0x8080, length 0x000C, 4 payload bytes AA BB CC DD, contiguous: o_udp_valid for 4 cycles starting 9 cycles after beat 0; o_udp_len = 4; o_src_udp_port = 0x1234; o_udp_last on DD; o_udp_err = 0.
- Same datagram padded to 18 IP bytes: output identical; padding bytes are not forwarded; the next packet, started back-to-back, is accepted.
- dst 0x9000 with the filter enabled: no output. Repeat after loading local port 0x9000: accepted.
- i_ip_type = 6 with a valid UDP header: no output.
- length 0x0010 but i_ip_last on payload byte 3: 4 bytes forwarded; last and err both asserted on the 4th byte.
- Random gaps in i_ip_valid during DATA: output gaps match the input with 1-cycle delay. Reset asserted during DATA: outputs go to 0 at once and the next clean datagram is received correctly.
